instr_fetch_unit: RTL and testbench

//  Multicycle fetch stage feeding the register file / decode. Owns the PC and issues
//  one instruction-memory read at a time over a valid/ready request channel.

---
 rtl/rv_pkg.sv | 15 +
 rtl/instr_fetch_unit.sv | 89 ++++++++
 tb/tb_instr_fetch_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV core definitions: datapath width, canonical NOP and fetch FSM encoding.
package rv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_FAULT
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch stage: owns the PC, issues one imem read at a time and holds the
// returned word in the IR until the core acknowledges it.
module instr_fetch_unit #(
  parameter int               XLEN     = rv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  input  logic            instr_ack,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            pc_redirect,
  input  logic [XLEN-1:0] pc_target,
  output logic            fetch_fault,
  output logic [31:0]     fetch_count
);

  import rv_pkg::*;

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc_q, instr_q, next_pc;
  logic [31:0]     count_q;
  logic            take_resp, take_ack, next_misaligned;

  assign pc_plus4        = pc_q + XLEN'(4);
  assign next_pc         = pc_redirect ? pc_target : pc_plus4;
  assign next_misaligned = (next_pc[1:0] != 2'b00);
  // Response and acknowledge are only meaningful in their own state; elsewhere they are stale.
  assign take_resp       = (state == ST_WAIT) && imem_resp_valid;
  assign take_ack        = (state == ST_HOLD) && instr_ack;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  state_next = ST_REQ;
      ST_REQ:   if (imem_req_ready) state_next = ST_WAIT;
      ST_WAIT:  if (imem_resp_valid) state_next = ST_HOLD;
      ST_HOLD:  if (instr_ack) state_next = next_misaligned ? ST_FAULT : ST_REQ;
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    instr_valid    = 1'b0;
    fetch_fault    = 1'b0;
    unique case (state)
      ST_REQ:   imem_req_valid = 1'b1;
      ST_HOLD:  instr_valid    = 1'b1;
      ST_FAULT: fetch_fault    = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= XLEN'(NOP_INSTR);
      count_q <= '0;
    end else begin
      if (take_resp) instr_q <= imem_rdata;
      if (take_ack) begin
        pc_q    <= next_pc;
        count_q <= count_q + 32'd1;
      end
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a one-cycle-latency memory model feeds a
// scoreboard of expected (pc, instr) pairs that is drained as instructions appear.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid, instr_ack;
  logic [31:0] pc, pc_plus4;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  logic        mem_auto;
  logic        auto_rv, man_rv;
  logic [31:0] auto_rdata, man_rdata;
  logic [31:0] exp_pc;
  int          acc_count;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb_pc[$];
  logic [31:0] sb_instr[$];

  assign imem_resp_valid = auto_rv | man_rv;
  assign imem_rdata      = man_rv ? man_rdata : auto_rdata;

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ack(instr_ack),
    .pc(pc), .pc_plus4(pc_plus4), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : ({a[23:0], 8'h13} ^ 32'h5A00_0000);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: accepted request (seen at negedge) is answered for one cycle after the edge.
  initial begin
    auto_rv = 1'b0;
    auto_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_auto && !reset && imem_req_valid && imem_req_ready) begin
        logic [31:0] a;
        a = exp_pc;
        check("req_addr", imem_addr, a);
        sb_pc.push_back(a);
        sb_instr.push_back(mem_word(a));
        @(posedge clk);
        #1;
        auto_rv = 1'b1;
        auto_rdata = mem_word(a);
        @(posedge clk);
        #1;
        auto_rv = 1'b0;
      end
    end
  end

  // Monitor: counts accepted requests and scores each newly presented instruction.
  initial begin
    logic prev_iv;
    prev_iv = 1'b0;
    acc_count = 0;
    forever begin
      @(negedge clk);
      if (!reset && imem_req_valid && imem_req_ready) acc_count++;
      if (instr_valid && !prev_iv) begin
        if (sb_pc.size() == 0) check("sb_unexpected_instr", 32'd1, 32'd0);
        else begin
          check("sb_pc", pc, sb_pc.pop_front());
          check("sb_instr", instr, sb_instr.pop_front());
        end
      end
      prev_iv = instr_valid;
    end
  end

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    if (!instr_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Acknowledge the held instruction and update the bench's own next-pc model.
  task automatic ack(input logic redir, input logic [31:0] tgt);
    instr_ack = 1'b1;
    pc_redirect = redir;
    pc_target = tgt;
    if (instr_valid) exp_pc = redir ? tgt : exp_pc + 32'd4;
    tick();
    instr_ack = 1'b0;
    pc_redirect = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    sb_pc.delete();
    sb_instr.delete();
    exp_pc = RESET_PC;
    reset = 1'b0;
  endtask

  initial begin
    int n, acc0;
    logic saw_req;
    reset = 1'b1;
    imem_req_ready = 1'b1;
    instr_ack = 1'b0;
    pc_redirect = 1'b0;
    pc_target = '0;
    man_rv = 1'b0;
    man_rdata = '0;
    mem_auto = 1'b1;
    exp_pc = RESET_PC;

    // 1: reset state and first fetch
    reset = 1'b1;
    tick();
    tick();
    check("rst_pc", pc, RESET_PC);
    check("rst_instr", instr, NOP);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    reset = 1'b0;
    wait_valid("first", n);
    check("first_latency", n, 32'd3);
    check("first_pc_plus4", pc_plus4, 32'h4);

    // 2: sequential ack, then redirected ack, ack-to-valid latency
    ack(1'b0, 32'h0);
    wait_valid("seq", n);
    check("seq_latency", n + 1, 32'd3);
    ack(1'b1, 32'h100);
    wait_valid("redir", n);
    check("redir_pc", pc, 32'h100);
    check("count_2", fetch_count, 32'd2);

    // 3: backpressure: request stays put and is accepted exactly once
    imem_req_ready = 1'b0;
    ack(1'b0, 32'h0);
    acc0 = acc_count;
    for (int i = 0; i < 5; i++) begin
      check("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("stall_addr", imem_addr, exp_pc);
      tick();
    end
    imem_req_ready = 1'b1;
    wait_valid("stall", n);
    check("stall_accepts", acc_count - acc0, 32'd1);

    // 6: pc wrap and ack ignored outside HOLD
    ack(1'b1, 32'hFFFF_FFFC);
    wait_valid("top", n);
    check("top_pc_plus4", pc_plus4, 32'h0);
    imem_req_ready = 1'b0;
    ack(1'b0, 32'h0);
    check("wrap_pc", pc, 32'h0);
    ack(1'b1, 32'h200);
    check("ign_ack_pc", pc, 32'h0);
    check("ign_ack_count", fetch_count, 32'd5);
    check("ign_ack_req", {31'd0, imem_req_valid}, 32'd1);
    imem_req_ready = 1'b1;
    wait_valid("wrap", n);

    // 4: misaligned target faults and stops fetching until reset
    ack(1'b1, 32'h102);
    check("fault_flag", {31'd0, fetch_fault}, 32'd1);
    check("fault_iv", {31'd0, instr_valid}, 32'd0);
    check("fault_count", fetch_count, 32'd6);
    saw_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (imem_req_valid) saw_req = 1'b1;
      tick();
    end
    check("fault_no_req", {31'd0, saw_req}, 32'd0);
    check("fault_sticky", {31'd0, fetch_fault}, 32'd1);
    mem_auto = 1'b0;
    do_reset();
    check("post_fault_pc", pc, RESET_PC);
    check("post_fault_flag", {31'd0, fetch_fault}, 32'd0);
    check("post_fault_count", fetch_count, 32'd0);

    // 5: reset while in WAIT; the late response must be discarded
    tick();
    tick();
    check("wait_no_iv", {31'd0, instr_valid}, 32'd0);
    check("wait_no_req", {31'd0, imem_req_valid}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    imem_req_ready = 1'b0;
    man_rv = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    man_rv = 1'b0;
    check("late_instr", instr, NOP);
    check("late_iv", {31'd0, instr_valid}, 32'd0);
    check("late_req_addr", imem_addr, RESET_PC);
    check("late_req_valid", {31'd0, imem_req_valid}, 32'd1);
    sb_pc.delete();
    sb_instr.delete();
    exp_pc = RESET_PC;
    mem_auto = 1'b1;
    imem_req_ready = 1'b1;
    wait_valid("after_late", n);
    tick();
    check("sb_drain", sb_pc.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
